// File: rtl/cp_irq_ctrl.sv
// APB-programmed interrupt controller: latches source events as pending, masks them, drives oInt.
// Source edge -> pending bit one edge later -> oInt two edges later; APB has no wait states.
module cp_irq_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int HOLD_W  = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iPsel,
    input  logic               iPenable,
    input  logic               iPwrite,
    input  logic [15:0]        iPaddr,
    input  logic [31:0]        iPwdata,
    output logic [31:0]        oPrdata,
    input  logic [NUM_SRC-1:0] iIrqSrc,
    output logic               oInt
);

    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

    state_t              state;
    logic [NUM_SRC-1:0]  ier;
    logic [NUM_SRC-1:0]  ipr;
    logic [NUM_SRC-1:0]  mode;
    logic [NUM_SRC-1:0]  src_dly;
    logic                gie;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   cnt;
    logic                pend_hold;

    logic [5:0]          off;
    logic                wr_en;
    logic                rd_en;
    logic [NUM_SRC-1:0]  w1c;
    logic [NUM_SRC-1:0]  set_vec;
    logic                active;
    logic [31:0]         rd_mux;
    logic                unused_bits;

    assign off     = iPaddr[7:2];
    assign wr_en   = iPsel & iPenable & iPwrite;
    assign rd_en   = iPsel & ~iPenable & ~iPwrite;
    assign w1c     = (wr_en && off == 6'h01) ? iPwdata[NUM_SRC-1:0] : '0;
    // Level-mode bits re-arm every cycle the source is high, so they beat a same-cycle W1C.
    assign set_vec = (iIrqSrc & mode) | (iIrqSrc & ~src_dly & ~mode);
    assign active  = gie & |(ipr & ier);
    assign unused_bits = ^{iPaddr[15:8], iPaddr[1:0], iPwdata};

    always_comb begin
        rd_mux = '0;
        case (off)
            6'h00:   rd_mux = 32'(ier);
            6'h01:   rd_mux = 32'(ipr);
            6'h02:   rd_mux = {31'b0, gie};
            6'h03:   rd_mux = 32'(iIrqSrc);
            6'h04:   rd_mux = 32'(mode);
            6'h05:   rd_mux = 32'(hold);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ier     <= '0;
            ipr     <= '0;
            mode    <= '0;
            src_dly <= '0;
            gie     <= 1'b0;
            hold    <= '0;
            oPrdata <= '0;
        end else begin
            src_dly <= iIrqSrc;
            ipr     <= (ipr & ~w1c) | set_vec;
            if (wr_en) begin
                case (off)
                    6'h00:   ier  <= iPwdata[NUM_SRC-1:0];
                    6'h02:   gie  <= iPwdata[0];
                    6'h04:   mode <= iPwdata[NUM_SRC-1:0];
                    6'h05:   hold <= iPwdata[HOLD_W-1:0];
                    default: ;
                endcase
            end
            if (rd_en) begin
                oPrdata <= rd_mux;
            end
        end
    end

    // Holdoff counts from the HOLD value latched on entry; later HOLD writes wait for the next entry.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_hold <= 1'b0;
            oInt      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (active || pend_hold) begin
                        state     <= ASSERT;
                        oInt      <= 1'b1;
                        pend_hold <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (!active) begin
                        oInt <= 1'b0;
                        if (hold == '0) begin
                            state <= IDLE;
                        end else begin
                            state <= HOLDOFF;
                            cnt   <= hold;
                        end
                    end
                end
                HOLDOFF: begin
                    if (active) begin
                        pend_hold <= 1'b1;
                    end
                    if (cnt == HOLD_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    oInt  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp_irq_ctrl.sv
// Directed bench for cp_irq_ctrl: APB register access, edge/level capture, masking, W1C collision, holdoff, reset.
module tb_cp_irq_ctrl;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iPsel;
    logic        iPenable;
    logic        iPwrite;
    logic [15:0] iPaddr;
    logic [31:0] iPwdata;
    logic [31:0] oPrdata;
    logic [3:0]  iIrqSrc;
    logic        oInt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    cp_irq_ctrl #(.NUM_SRC(4), .HOLD_W(8)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iPsel    (iPsel),
        .iPenable (iPenable),
        .iPwrite  (iPwrite),
        .iPaddr   (iPaddr),
        .iPwdata  (iPwdata),
        .oPrdata  (oPrdata),
        .iIrqSrc  (iIrqSrc),
        .oInt     (oInt)
    );

    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty obs=%h exp=none", obs);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk_int(input string tag, input logic exp);
        push(tag, {31'b0, exp});
        pop_check({31'b0, oInt});
    endtask

    // src_acc is OR-ed onto the sources during the access cycle only, to line events up with the commit edge.
    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] src_acc);
        iPsel    = 1'b1;
        iPenable = 1'b0;
        iPwrite  = 1'b1;
        iPaddr   = addr;
        iPwdata  = data;
        tick();
        iPenable = 1'b1;
        iIrqSrc  = iIrqSrc | src_acc;
        tick();
        iIrqSrc  = iIrqSrc & ~src_acc;
        iPsel    = 1'b0;
        iPenable = 1'b0;
        iPwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] addr, input logic [31:0] exp, input string tag);
        push(tag, exp);
        iPsel    = 1'b1;
        iPenable = 1'b0;
        iPwrite  = 1'b0;
        iPaddr   = addr;
        tick();
        iPenable = 1'b1;
        pop_check(oPrdata);
        tick();
        iPsel    = 1'b0;
        iPenable = 1'b0;
    endtask

    initial begin
        iRst     = 1'b1;
        iPsel    = 1'b0;
        iPenable = 1'b0;
        iPwrite  = 1'b0;
        iPaddr   = '0;
        iPwdata  = '0;
        iIrqSrc  = '0;
        repeat (2) @(posedge iClk);
        #3 iRst = 1'b0;
        tick();
        chk_int("reset_int", 1'b0);
        push("reset_prdata", 32'h0);
        pop_check(oPrdata);

        // Edge path
        apb_write(16'hA000, 32'h1, 4'h0);
        apb_write(16'hA008, 32'h1, 4'h0);
        apb_read(16'hA008, 32'h1, "gie_rb");
        iIrqSrc = 4'h1;
        tick();
        chk_int("edge_int_n1", 1'b0);
        iIrqSrc = 4'h0;
        tick();
        chk_int("edge_int_n2", 1'b1);
        apb_read(16'hA004, 32'h1, "edge_ipr");
        apb_write(16'hA004, 32'h1, 4'h0);
        chk_int("w1c_int_commit", 1'b1);
        tick();
        chk_int("w1c_int_next", 1'b0);
        apb_read(16'hA004, 32'h0, "w1c_ipr");

        // Masking
        apb_write(16'hA000, 32'h2, 4'h0);
        iIrqSrc = 4'h1;
        tick();
        iIrqSrc = 4'h0;
        tick();
        tick();
        chk_int("mask_int_low", 1'b0);
        apb_read(16'hA004, 32'h1, "mask_ipr");
        apb_write(16'hA000, 32'h3, 4'h0);
        chk_int("unmask_commit", 1'b0);
        tick();
        chk_int("unmask_next", 1'b1);
        apb_write(16'hA004, 32'h1, 4'h0);
        tick();
        chk_int("mask_clear", 1'b0);

        // Level mode
        apb_write(16'hA010, 32'h2, 4'h0);
        apb_read(16'hA010, 32'h2, "mode_rb");
        iIrqSrc = 4'h2;
        tick();
        tick();
        chk_int("level_int", 1'b1);
        apb_read(16'hA00C, 32'h2, "raw_rb");
        apb_write(16'hA004, 32'h2, 4'h0);
        tick();
        chk_int("level_w1c_int", 1'b1);
        apb_read(16'hA004, 32'h2, "level_w1c_ipr");
        iIrqSrc = 4'h0;
        tick();
        apb_write(16'hA004, 32'h2, 4'h0);
        tick();
        chk_int("level_drop_int", 1'b0);
        apb_read(16'hA004, 32'h0, "level_drop_ipr");

        // Collision: rising edge on src2 at the same edge as its W1C
        iIrqSrc = 4'h4;
        tick();
        iIrqSrc = 4'h0;
        tick();
        apb_read(16'hA004, 32'h4, "coll_pre_ipr");
        apb_write(16'hA004, 32'h4, 4'h4);
        apb_read(16'hA004, 32'h4, "coll_ipr");
        chk_int("coll_int", 1'b0);
        apb_write(16'hA004, 32'h4, 4'h0);
        apb_read(16'hA004, 32'h0, "coll_clear_ipr");

        // Holdoff
        apb_write(16'hA014, 32'h5, 4'h0);
        apb_read(16'hA014, 32'h5, "hold_rb");
        iIrqSrc = 4'h1;
        tick();
        iIrqSrc = 4'h0;
        tick();
        chk_int("hold_pre_int", 1'b1);
        apb_write(16'hA004, 32'h1, 4'h0);
        iIrqSrc = 4'h1;
        for (int i = 0; i < 6; i++) push("holdoff_low", 32'h0);
        push("holdoff_reassert", 32'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            iIrqSrc = 4'h0;
            pop_check({31'b0, oInt});
        end
        apb_read(16'hA018, 32'h0, "unmapped_rd");

        // Asynchronous reset mid-cycle while asserted
        apb_read(16'hA004, 32'h1, "pre_rst_ipr");
        #2 iRst = 1'b1;
        #1;
        chk_int("async_rst_int", 1'b0);
        push("async_rst_prdata", 32'h0);
        pop_check(oPrdata);
        #1 iRst = 1'b0;
        apb_read(16'hA000, 32'h0, "rst_ier");
        apb_read(16'hA004, 32'h0, "rst_ipr");
        apb_read(16'hA008, 32'h0, "rst_gie");
        apb_read(16'hA010, 32'h0, "rst_mode");
        apb_read(16'hA014, 32'h0, "rst_hold");
        apb_write(16'hA000, 32'hFFFF_FFFF, 4'h0);
        apb_read(16'hA000, 32'hF, "ier_upper_bits");
        chk_int("final_int", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
